// File: rtl/servo_sweep_sequencer_if.sv
// Avalon-MM slave bus between the Nios II interconnect and the servo sweep sequencer.
// Reads are combinational (latency 0), so readdata is driven by the slave in the read cycle.
interface servo_sweep_sequencer_if;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;

    modport master (
        output address,
        output write,
        output writedata,
        output read,
        input  readdata
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        input  read,
        output readdata
    );
endinterface

// File: rtl/servo_sweep_sequencer.sv
// Sweeps the servo angle between MIN and MAX one degree per frame, pausing at each
// endpoint with an interrupt until software acknowledges by clearing irq_pending.
module servo_sweep_sequencer #(
    parameter int CLK_PER_STEP = 1_000_000,
    parameter int ANGLE_LIMIT  = 180
) (
    input  logic                          clk,
    input  logic                          reset,
    servo_sweep_sequencer_if.slave        bus,
    output logic                          irq,
    output logic [7:0]                    angle,
    output logic                          angle_step
);
    localparam int                CNT_W    = $clog2(CLK_PER_STEP);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_PER_STEP - 1);
    localparam logic [7:0]        LIMIT    = 8'(ANGLE_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_WAIT_TOP,
        S_DOWN,
        S_WAIT_BOT
    } state_t;

    state_t           state_reg, state_next;
    logic [7:0]       angle_reg, angle_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             pending_reg, pending_next;
    logic             dir_reg, dir_next;
    logic             step_reg, step_next;
    logic [7:0]       min_reg, max_reg;
    logic             run_reg, irq_en_reg;

    logic [2:0]       wr_sel;
    logic [7:0]       wdata_clamped;
    logic             tick;
    logic             unused_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_wr_sel
            assign wr_sel[gi] = bus.write && (bus.address == 2'(gi));
        end
    endgenerate

    assign wdata_clamped = (bus.writedata[7:0] > LIMIT) ? LIMIT : bus.writedata[7:0];
    assign unused_wdata  = ^{bus.writedata[31:10], bus.writedata[8]};
    assign tick          = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            angle_reg   <= 8'd0;
            cnt_reg     <= '0;
            pending_reg <= 1'b0;
            dir_reg     <= 1'b1;
            step_reg    <= 1'b0;
            min_reg     <= 8'd45;
            max_reg     <= 8'd135;
            run_reg     <= 1'b0;
            irq_en_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            angle_reg   <= angle_next;
            cnt_reg     <= cnt_next;
            pending_reg <= pending_next;
            dir_reg     <= dir_next;
            step_reg    <= step_next;
            if (wr_sel[0]) min_reg <= wdata_clamped;
            if (wr_sel[1]) max_reg <= wdata_clamped;
            if (wr_sel[2]) begin
                run_reg    <= bus.writedata[0];
                irq_en_reg <= bus.writedata[1];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        angle_next   = angle_reg;
        cnt_next     = cnt_reg;
        pending_next = pending_reg;
        dir_next     = dir_reg;
        step_next    = 1'b0;

        // W1C first so that an endpoint set in the same cycle overrides it.
        if (wr_sel[2] && bus.writedata[9]) pending_next = 1'b0;

        if (!run_reg) begin
            state_next = S_IDLE;
            cnt_next   = '0;
        end else begin
            unique case (state_reg)
                S_IDLE: begin
                    angle_next = min_reg;
                    dir_next   = 1'b1;
                    step_next  = 1'b1;
                    cnt_next   = '0;
                    state_next = S_UP;
                end
                S_UP: begin
                    cnt_next = tick ? '0 : cnt_reg + CNT_W'(1);
                    if (tick) begin
                        if ({1'b0, angle_reg} + 9'd1 >= {1'b0, max_reg}) begin
                            angle_next   = max_reg;
                            pending_next = 1'b1;
                            step_next    = (max_reg != angle_reg);
                            state_next   = S_WAIT_TOP;
                        end else begin
                            angle_next = angle_reg + 8'd1;
                            step_next  = 1'b1;
                        end
                    end
                end
                S_WAIT_TOP: begin
                    cnt_next = '0;
                    if (!pending_reg) begin
                        dir_next   = 1'b0;
                        state_next = S_DOWN;
                    end
                end
                S_DOWN: begin
                    cnt_next = tick ? '0 : cnt_reg + CNT_W'(1);
                    if (tick) begin
                        // angle-1 <= MIN rewritten as angle <= MIN+1 to avoid wrap at 0
                        if (angle_reg == 8'd0 || {1'b0, angle_reg} <= {1'b0, min_reg} + 9'd1) begin
                            angle_next   = min_reg;
                            pending_next = 1'b1;
                            step_next    = (min_reg != angle_reg);
                            state_next   = S_WAIT_BOT;
                        end else begin
                            angle_next = angle_reg - 8'd1;
                            step_next  = 1'b1;
                        end
                    end
                end
                S_WAIT_BOT: begin
                    cnt_next = '0;
                    if (!pending_reg) begin
                        dir_next   = 1'b1;
                        state_next = S_UP;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.readdata = 32'd0;
        if (bus.read) begin
            case (bus.address)
                2'd0:    bus.readdata = {24'd0, min_reg};
                2'd1:    bus.readdata = {24'd0, max_reg};
                2'd2:    bus.readdata = {22'd0, pending_reg, dir_reg, 6'd0, irq_en_reg, run_reg};
                default: bus.readdata = {24'd0, angle_reg};
            endcase
        end
    end

    assign irq        = pending_reg & irq_en_reg;
    assign angle      = angle_reg;
    assign angle_step = step_reg;
endmodule

// File: tb/tb_servo_sweep_sequencer.sv
// Bench for servo_sweep_sequencer: expected angle steps (value, edge, irq) are queued when
// a sweep is started or acknowledged; a negedge monitor pops and compares each angle_step.
module tb_servo_sweep_sequencer;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       irq;
    logic [7:0] angle;
    logic       angle_step;

    servo_sweep_sequencer_if bus ();

    servo_sweep_sequencer #(.CLK_PER_STEP(P), .ANGLE_LIMIT(180)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .irq        (irq),
        .angle      (angle),
        .angle_step (angle_step)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int ang;
        int at;
        bit ie;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // Reference model state
    int m_min = 45, m_max = 135, m_angle = 0;
    bit m_en = 1'b0;
    bit next_down = 1'b1;
    int seg_end = 0;
    int run_edge = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && angle_step === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_step: actual angle=%0d at cycle %0d, required no step", angle, cyc);
            end else begin
                mon_e = sb.pop_front();
                $display("step cycle=%0d angle=%0d irq=%0b", cyc, angle, irq);
                check("step_angle", 32'(angle), 32'(mon_e.ang));
                check("step_cycle", 32'(cyc), 32'(mon_e.at));
                check("step_irq", 32'(irq), 32'(mon_e.ie));
            end
        end else if (!reset && sb.size() > 0 && sb[0].at < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_step: actual none by cycle %0d, required angle=%0d at cycle %0d",
                     cyc, sb[0].ang, sb[0].at);
            void'(sb.pop_front());
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        @(posedge clk);
        #1;
        bus.write = 1'b0;
        $display("write addr=%0d data=0x%0h edge=%0d", a, d, cyc);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a;
        bus.read    = 1'b1;
        #1;
        d        = bus.readdata;
        bus.read = 1'b0;
        $display("read  addr=%0d data=0x%0h cycle=%0d", a, d, cyc);
    endtask

    task automatic push(input int a, input int at, input bit ie);
        exp_t e;
        e.ang = a;
        e.at  = at;
        e.ie  = ie;
        sb.push_back(e);
    endtask

    // Up: angles climb one per step and the step that reaches or passes MAX lands on MAX.
    task automatic push_up(input int s);
        int n;
        n = (m_max > m_angle) ? m_max - m_angle : 1;
        for (int k = 1; k <= n; k++)
            push((k == n) ? m_max : m_angle + k, s + k * P, (k == n) && m_en);
        m_angle   = m_max;
        seg_end   = s + n * P;
        next_down = 1'b1;
    endtask

    task automatic push_down(input int s);
        int n;
        n = (m_angle > m_min) ? m_angle - m_min : 1;
        for (int k = 1; k <= n; k++)
            push((k == n) ? m_min : m_angle - k, s + k * P, (k == n) && m_en);
        m_angle   = m_min;
        seg_end   = s + n * P;
        next_down = 1'b0;
    endtask

    task automatic write_bounds(input int mn, input int mx);
        logic [31:0] d;
        bus_write(2'd0, 32'(mn));
        bus_write(2'd1, 32'(mx));
        m_min = (mn > 180) ? 180 : mn;
        m_max = (mx > 180) ? 180 : mx;
        bus_read(2'd0, d);
        check("min_readback", d, 32'(m_min));
        bus_read(2'd1, d);
        check("max_readback", d, 32'(m_max));
    endtask

    task automatic start_run(input bit en);
        m_en = en;
        bus_write(2'd2, {30'd0, en, 1'b1});
        run_edge = cyc;
        m_angle  = m_min;
        push(m_min, run_edge + 1, 1'b0);
        push_up(run_edge + 1);
    endtask

    task automatic ack();
        bus_write(2'd2, 32'h200 | {30'd0, m_en, 1'b1});
        if (next_down) push_down(cyc + 1);
        else           push_up(cyc + 1);
    endtask

    task automatic wait_end();
        logic [31:0] d;
        while (cyc < seg_end) @(negedge clk);
        bus_read(2'd2, d);
        check("endpoint_pending", 32'(d[9]), 32'd1);
        check("endpoint_irq", 32'(irq), 32'(m_en));
        bus_read(2'd3, d);
        check("endpoint_angle", d, 32'(m_angle));
    endtask

    task automatic stop();
        bus_write(2'd2, 32'h200);
        check("queue_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic reset_checks();
        logic [31:0] d;
        bus_read(2'd0, d); check("reset_min", d, 32'd45);
        bus_read(2'd1, d); check("reset_max", d, 32'd135);
        bus_read(2'd2, d); check("reset_ctrl", d, 32'h100);
        bus_read(2'd3, d); check("reset_angle", d, 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_angle_step", 32'(angle_step), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int s;
        int mn, mx, span;
        bit en;

        bus.address   = 2'd0;
        bus.write     = 1'b0;
        bus.writedata = 32'd0;
        bus.read      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        reset_checks();

        // Basic sweep 10..13 and back, with hold until acknowledge
        write_bounds(10, 13);
        start_run(1'b1);
        wait_end();
        repeat (2 * P) @(negedge clk);
        ack();
        wait_end();
        ack();
        // W1C landing on the same edge as the top endpoint: set must win
        while (cyc < seg_end - 2) @(negedge clk);
        bus_write(2'd2, 32'h203);
        bus_read(2'd2, d);
        check("set_beats_w1c", 32'(d[9]), 32'd1);
        repeat (2 * P) @(negedge clk);
        ack();
        wait_end();
        stop();

        // Clamping of MAX and an immediate endpoint
        write_bounds(179, 200);
        start_run(1'b1);
        wait_end();
        stop();

        // MAX lowered below the current angle mid-sweep snaps on the next tick
        write_bounds(18, 30);
        m_en = 1'b1;
        bus_write(2'd2, 32'h3);
        s = cyc + 1;
        push(18, s, 1'b0);
        push(19, s + P, 1'b0);
        push(20, s + 2 * P, 1'b0);
        while (cyc < s + 2 * P) @(negedge clk);
        bus_write(2'd1, 32'd15);
        m_max = 15;
        push(15, s + 3 * P, 1'b1);
        m_angle = 15;
        seg_end = s + 3 * P;
        wait_end();
        stop();

        // Endpoint with irq masked, then unmask, then run cleared during DOWN
        write_bounds(40, 43);
        start_run(1'b0);
        wait_end();
        bus_write(2'd2, 32'h3);
        check("irq_after_enable", 32'(irq), 32'd1);
        m_en = 1'b1;
        bus_write(2'd2, 32'h203);
        s = cyc + 1;
        push(42, s + P, 1'b0);
        m_angle = 42;
        while (cyc < s + P) @(negedge clk);
        bus_write(2'd2, 32'h2);
        repeat (3 * P) @(negedge clk);
        bus_read(2'd3, d);
        check("frozen_angle", d, 32'd42);
        bus_read(2'd2, d);
        check("ctrl_after_stop", d, 32'h2);
        check("no_steps_after_stop", 32'(sb.size()), 32'd0);

        // Reset in the middle of an up sweep
        write_bounds(50, 60);
        start_run(1'b1);
        while (cyc < run_edge + 1 + P) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        check("midreset_angle", 32'(angle), 32'd0);
        check("midreset_step", 32'(angle_step), 32'd0);
        check("midreset_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_min = 45; m_max = 135; m_angle = 0; m_en = 1'b0;
        reset_checks();
        repeat (2 * P) @(negedge clk);

        // Randomized sweeps, including inverted bounds (MIN > MAX bounce)
        for (int it = 0; it < 6; it++) begin
            stop();
            do mn = int'($urandom_range(6, 174)); while (mn == m_angle);
            span = int'($urandom_range(1, 6));
            mx   = ($urandom_range(0, 3) == 0) ? mn - span : mn + span;
            en   = 1'($urandom_range(0, 1));
            write_bounds(mn, mx);
            start_run(en);
            wait_end();
            ack();
            wait_end();
            ack();
            wait_end();
        end
        stop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
